// File: rtl/qadd_pipe.sv
// qadd_pipe: two-stage pipelined sign-magnitude fixed-point adder/subtractor with valid/ready.
// Build option: define QADD_SAT_EN to saturate overflowing results to +/-max instead of wrapping.
module qadd_pipe #(
    parameter int unsigned N = 32,
    parameter int unsigned Q = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int unsigned M = N - 1;

    // Q only documents the operand format; both operands share it, so no alignment is needed.
    if (N < 4 || N > 64 || Q >= N - 1) begin : gen_param_check
        $error("qadd_pipe: illegal N/Q combination");
    end

    logic         en1;
    logic         en2;

    logic         s1_valid_q, s1_valid_d;
    logic         s1_ge_q, s1_ge_d;
    logic         s1_sub_q, s1_sub_d;
    logic [M-1:0] s1_ma_q, s1_ma_d;
    logic [M-1:0] s1_mb_q, s1_mb_d;
    logic         s1_sa_q, s1_sa_d;
    logic         s1_sb_q, s1_sb_d;

    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] c_q, c_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] sum;
    logic [M-1:0] diff;
    logic [M-1:0] mag;
    logic         sign;
    logic         ovf_raw;

    always_comb begin
        en2      = !s2_valid_q || out_ready;
        en1      = !s1_valid_q || en2;
        in_ready = en1 && rst_n;
    end

    // Stage 1: capture magnitudes, effective signs and the magnitude comparison.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ge_d    = s1_ge_q;
        s1_sub_d   = s1_sub_q;
        s1_ma_d    = s1_ma_q;
        s1_mb_d    = s1_mb_q;
        s1_sa_d    = s1_sa_q;
        s1_sb_d    = s1_sb_q;
        if (en1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ma_d  = a[N-2:0];
                s1_mb_d  = b[N-2:0];
                s1_sa_d  = a[N-1];
                s1_sb_d  = b[N-1] ^ op;
                s1_sub_d = a[N-1] ^ b[N-1] ^ op;
                s1_ge_d  = (a[N-2:0] >= b[N-2:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ge_q    <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_ma_q    <= '0;
            s1_mb_q    <= '0;
            s1_sa_q    <= 1'b0;
            s1_sb_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ge_q    <= s1_ge_d;
            s1_sub_q   <= s1_sub_d;
            s1_ma_q    <= s1_ma_d;
            s1_mb_q    <= s1_mb_d;
            s1_sa_q    <= s1_sa_d;
            s1_sb_q    <= s1_sb_d;
        end
    end

    // Stage 2 arithmetic: add magnitudes on equal signs, else subtract smaller from larger.
    always_comb begin
        sum     = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};
        diff    = s1_ge_q ? (s1_ma_q - s1_mb_q) : (s1_mb_q - s1_ma_q);
        ovf_raw = 1'b0;
        if (s1_sub_q) begin
            mag  = diff;
            sign = s1_ge_q ? s1_sa_q : s1_sb_q;
        end else begin
            ovf_raw = sum[N-1];
            mag     = sum[M-1:0];
            sign    = s1_sa_q;
`ifdef QADD_SAT_EN
            if (ovf_raw) begin
                mag = '1;
            end
`endif
        end
        // Negative zero is never emitted; this also covers equal magnitudes and -0 inputs.
        if (mag == '0) begin
            sign = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        c_d        = c_q;
        ovf_d      = ovf_q;
        if (en2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d   = {sign, mag};
                ovf_d = ovf_raw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            c_q        <= c_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(c) && $stable(ovf));

    a_no_negative_zero: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> !(c[N-1] && (c[N-2:0] == '0)));

endmodule

// File: tb/tb_qadd_pipe.sv
// Directed and model-checked bench for qadd_pipe (N=32, Q=15); honours QADD_SAT_EN like the DUT.
module tb_qadd_pipe;

    localparam int unsigned N = 32;
    localparam int unsigned Q = 15;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    int n_checks;
    int n_errors;

    qadd_pipe #(
        .N(N),
        .Q(Q)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer arithmetic on decoded values, then re-encode to sign-magnitude.
    function automatic logic [32:0] ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                              input logic rop);
        longint va, vb, r, m;
        logic   o, s;
        va = longint'(ra[30:0]);
        if (ra[31]) va = -va;
        vb = longint'(rb[30:0]);
        if (rb[31] ^ rop) vb = -vb;
        r = va + vb;
        m = (r < 0) ? -r : r;
        o = (m > longint'(32'h7FFF_FFFF));
`ifdef QADD_SAT_EN
        if (o) m = longint'(32'h7FFF_FFFF);
`else
        m = m & longint'(32'h7FFF_FFFF);
`endif
        s = (r < 0) && (m != 0);
        return {o, s, m[30:0]};
    endfunction

    // Offer one pair with out_ready high and check the two-cycle latency and the result.
    task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                              input logic top, input logic [31:0] ec, input logic eo);
        a         = ta;
        b         = tbv;
        op        = top;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_valid_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_c"}, 64'(c), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [31:0] ra, rb;
    logic        rop;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", 64'(c), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        #1 check("rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_single("mixed_add", 32'h0000_C000, 32'h8000_4000, 1'b0, 32'h0000_8000, 1'b0);
        run_single("sub_cross", 32'h0000_4000, 32'h0000_C000, 1'b1, 32'h8000_8000, 1'b0);
        run_single("equal_cancel", 32'h0000_8000, 32'h8000_8000, 1'b0, 32'h0000_0000, 1'b0);
        run_single("neg_zero", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0);
`ifdef QADD_SAT_EN
        run_single("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1);
`else
        run_single("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
`endif

        // Backpressure: two pairs buffer, the third is refused until out_ready rises.
        out_ready = 1'b0;
        a = 32'h0001_0000; b = 32'h0000_8000; op = 1'b0; in_valid = 1'b1;
        #1 check("bp_ready0", 64'(in_ready), 64'd1);
        @(negedge clk);
        a = 32'h8001_0000; b = 32'h0000_8000; op = 1'b0;
        #1 check("bp_ready1", 64'(in_ready), 64'd1);
        @(negedge clk);
        a = 32'h0000_1000; b = 32'h0000_3000; op = 1'b1;
        #1 check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_full_valid", 64'(out_valid), 64'd1);
        check("bp_full_c", 64'(c), 64'h0001_8000);
        @(negedge clk);
        #1 check("bp_hold_c", 64'(c), 64'h0001_8000);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1 check("bp_ready_comb", 64'(in_ready), 64'd1);
        check("bp_drain0_valid", 64'(out_valid), 64'd1);
        check("bp_drain0_c", 64'(c), 64'h0001_8000);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_drain1_valid", 64'(out_valid), 64'd1);
        check("bp_drain1_c", 64'(c), 64'h8000_8000);
        @(negedge clk);
        check("bp_drain2_valid", 64'(out_valid), 64'd1);
        check("bp_drain2_c", 64'(c), 64'h8000_2000);
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);

        // Streaming: 16 random pairs back to back, results compared in order.
        for (int i = 0; i < 20; i++) begin
            if (i >= 2 && i < 18) begin
                check("stream_valid", 64'(out_valid), 64'd1);
                e = exp_q.pop_front();
                check("stream_c", 64'(c), 64'(e[31:0]));
                check("stream_ovf", 64'(ovf), 64'(e[32]));
            end else begin
                check("stream_idle", 64'(out_valid), 64'd0);
            end
            if (i < 16) begin
                ra       = $urandom();
                rb       = $urandom();
                rop      = 1'($urandom_range(1, 0));
                a        = ra;
                b        = rb;
                op       = rop;
                in_valid = 1'b1;
                exp_q.push_back(ref_model(ra, rb, rop));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Mid-flight reset with two pairs in the pipe.
        a = 32'h0000_1000; b = 32'h0000_2000; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h0000_0100; b = 32'h0000_0200; op = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_pre_valid", 64'(out_valid), 64'd1);
        check("mr_pre_c", 64'(c), 64'h0000_3000);
        rst_n = 1'b0;
        #1 check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_c", 64'(c), 64'd0);
        check("mr_ovf", 64'(ovf), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("mr_no_stale", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        run_single("recover", 32'h8000_1000, 32'h0000_0800, 1'b1, 32'h8000_1800, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
